// File: rtl/snn_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_cfg_pkg
// Description : Shared constants and FSM state type for the SNN config path.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_cfg_pkg;

  localparam int NUM_LAYERS        = 5;
  localparam int NCFG_WIDTH        = 96;
  localparam int CHAIN_LEN_DEFAULT = NUM_LAYERS * NCFG_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/network_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : network_cfg_ctrl
// Description : Serializes host config bytes onto the SNN scan chain and
//               returns the bits falling out of the chain as readback bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module network_cfg_ctrl
  import snn_cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEFAULT,
  parameter int WORD_WIDTH = 8,
  parameter int BCNT_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  WR_VALID,
  input  logic [WORD_WIDTH-1:0] WR_DATA,
  output logic                  WR_READY,
  output logic                  RD_VALID,
  output logic [WORD_WIDTH-1:0] RD_DATA,
  input  logic                  RD_READY,
  output logic                  CFG_WE,
  output logic                  CFG_D,
  input  logic                  CFG_Q,
  output logic                  BUSY,
  output logic                  NET_EN
);

  localparam int                    c_idx_w     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BCNT_WIDTH-1:0] c_chain_len = BCNT_WIDTH'(CHAIN_LEN);
  localparam logic [BCNT_WIDTH-1:0] c_word_len  = BCNT_WIDTH'(WORD_WIDTH);
  localparam logic [c_idx_w-1:0]    c_word_last = c_idx_w'(WORD_WIDTH - 1);

  cfg_state_e              r_state;
  logic [WORD_WIDTH-1:0]   r_sh_reg;
  logic [WORD_WIDTH-1:0]   r_rb_reg;
  logic [WORD_WIDTH-1:0]   r_rd_data;
  logic [BCNT_WIDTH-1:0]   r_bit_cnt;
  logic [c_idx_w-1:0]      r_bit_idx;
  logic [c_idx_w-1:0]      r_last_idx;
  logic                    r_rd_valid;
  logic                    r_cfg_we;
  logic                    r_cfg_d;
  logic                    r_net_en;

  logic [BCNT_WIDTH-1:0]   w_remaining;
  logic [BCNT_WIDTH-1:0]   w_bit_cnt_nxt;
  logic [c_idx_w-1:0]      w_last_idx;
  logic [WORD_WIDTH-1:0]   w_rb_final;
  logic                    w_last_bit;
  logic                    w_wr_fire;

  // Readback slot frees on the same cycle the host drains it, keeping WORD_WIDTH+1 cycles per byte.
  assign WR_READY  = (r_state == ST_FETCH) && (!r_rd_valid || RD_READY);
  assign BUSY      = (r_state != ST_IDLE);
  assign RD_VALID  = r_rd_valid;
  assign RD_DATA   = r_rd_data;
  assign CFG_WE    = r_cfg_we;
  assign CFG_D     = r_cfg_d;
  assign NET_EN    = r_net_en;
  assign w_wr_fire = WR_VALID && WR_READY;

  always_comb begin
    w_remaining   = c_chain_len - r_bit_cnt;
    w_bit_cnt_nxt = r_bit_cnt + BCNT_WIDTH'(1);
    w_last_idx    = (w_remaining >= c_word_len) ? c_word_last
                                                : c_idx_w'(w_remaining - BCNT_WIDTH'(1));
    w_rb_final            = r_rb_reg;
    w_rb_final[r_bit_idx] = CFG_Q;
    w_last_bit            = (r_bit_idx == r_last_idx);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state    <= ST_IDLE;
      r_sh_reg   <= '0;
      r_rb_reg   <= '0;
      r_rd_data  <= '0;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= '0;
      r_rd_valid <= 1'b0;
      r_cfg_we   <= 1'b0;
      r_cfg_d    <= 1'b0;
      r_net_en   <= 1'b0;
    end else begin
      if (RD_READY) begin
        r_rd_valid <= 1'b0;
      end
      if (ABORT) begin
        r_state  <= ST_IDLE;
        r_cfg_we <= 1'b0;
        r_net_en <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START) begin
              r_state   <= ST_FETCH;
              r_net_en  <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          ST_FETCH: begin
            if (w_wr_fire) begin
              r_cfg_d    <= WR_DATA[0];
              r_cfg_we   <= 1'b1;
              r_sh_reg   <= WR_DATA >> 1;
              r_rb_reg   <= '0;
              r_bit_idx  <= '0;
              r_last_idx <= w_last_idx;
              r_state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            // CFG_Q is the bit leaving the chain on this same edge.
            r_rb_reg  <= w_rb_final;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= r_bit_idx + c_idx_w'(1);
            if (w_last_bit) begin
              r_cfg_we   <= 1'b0;
              r_rd_data  <= w_rb_final;
              r_rd_valid <= 1'b1;
              if (w_bit_cnt_nxt == c_chain_len) begin
                r_state  <= ST_IDLE;
                r_net_en <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end else begin
              r_cfg_d  <= r_sh_reg[0];
              r_sh_reg <= r_sh_reg >> 1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_network_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_cfg_ctrl
// Description : Directed bench for network_cfg_ctrl with scan-chain models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_cfg_ctrl;

  localparam int LEN_A = 480;
  localparam int LEN_B = 13;

  typedef struct {
    logic       is_b;
    logic [7:0] wr_byte;
    logic [7:0] rb_first;
    logic [7:0] rb_last;
    int         nbytes;
    int         nbits;
    int         latency;
    int         stall;
    int         start_bit;
    logic       check_rb;
  } vec_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic wr_valid = 1'b0;
  logic rd_ready = 1'b0;
  logic sel = 1'b0;
  logic init_chain = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] cur_byte = 8'h00;

  logic wr_ready_a, rd_valid_a, cfg_we_a, cfg_d_a, cfg_q_a, busy_a, net_en_a;
  logic wr_ready_b, rd_valid_b, cfg_we_b, cfg_d_b, cfg_q_b, busy_b, net_en_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic [LEN_A-1:0] chain_a;
  logic [LEN_B-1:0] chain_b;

  logic        m_wr_ready, m_rd_valid, m_cfg_we, m_cfg_d, m_busy, m_net_en;
  logic [7:0]  m_rd_data;
  logic [13:0] m_outs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int d_err = 0;
  int hs_cnt = 0;
  int net_en_edge = -1;
  logic [7:0] rb_q[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  network_cfg_ctrl #(.CHAIN_LEN(LEN_A), .WORD_WIDTH(8), .BCNT_WIDTH(9)) u_dut_a (
    .CLK(clk), .RSTB(rstb), .START(start & ~sel), .ABORT(abort & ~sel),
    .WR_VALID(wr_valid & ~sel), .WR_DATA(wr_data), .WR_READY(wr_ready_a),
    .RD_VALID(rd_valid_a), .RD_DATA(rd_data_a), .RD_READY(rd_ready),
    .CFG_WE(cfg_we_a), .CFG_D(cfg_d_a), .CFG_Q(cfg_q_a),
    .BUSY(busy_a), .NET_EN(net_en_a)
  );

  network_cfg_ctrl #(.CHAIN_LEN(LEN_B), .WORD_WIDTH(8), .BCNT_WIDTH(4)) u_dut_b (
    .CLK(clk), .RSTB(rstb), .START(start & sel), .ABORT(abort & sel),
    .WR_VALID(wr_valid & sel), .WR_DATA(wr_data), .WR_READY(wr_ready_b),
    .RD_VALID(rd_valid_b), .RD_DATA(rd_data_b), .RD_READY(rd_ready),
    .CFG_WE(cfg_we_b), .CFG_D(cfg_d_b), .CFG_Q(cfg_q_b),
    .BUSY(busy_b), .NET_EN(net_en_b)
  );

  // Scan-chain models: bit 0 is the end nearest CFG_Q.
  always @(posedge clk) begin
    if (init_chain) begin
      chain_a <= '0;
      chain_b <= 13'h1A5B;
    end else begin
      if (cfg_we_a) chain_a <= {cfg_d_a, chain_a[LEN_A-1:1]};
      if (cfg_we_b) chain_b <= {cfg_d_b, chain_b[LEN_B-1:1]};
    end
  end
  assign cfg_q_a = chain_a[0];
  assign cfg_q_b = chain_b[0];

  assign m_wr_ready = sel ? wr_ready_b : wr_ready_a;
  assign m_rd_valid = sel ? rd_valid_b : rd_valid_a;
  assign m_rd_data  = sel ? rd_data_b  : rd_data_a;
  assign m_cfg_we   = sel ? cfg_we_b   : cfg_we_a;
  assign m_cfg_d    = sel ? cfg_d_b    : cfg_d_a;
  assign m_busy     = sel ? busy_b     : busy_a;
  assign m_net_en   = sel ? net_en_b   : net_en_a;
  assign m_outs     = {m_wr_ready, m_rd_valid, m_rd_data, m_cfg_we, m_cfg_d, m_busy, m_net_en};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_cfg_we) begin
      if (m_cfg_d !== cur_byte[we_cnt % 8]) d_err++;
      we_cnt++;
    end
    if (wr_valid && m_wr_ready) hs_cnt++;
    if (m_rd_valid && rd_ready) rb_q.push_back(m_rd_data);
    if (m_net_en === 1'b1 && net_en_edge < 0) net_en_edge = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int start_edge;
    int t;
    int stall_err;
    logic sdone;
    logic [LEN_A-1:0] exp_a;
    logic [LEN_B-1:0] exp_b;
    for (int i = 0; i < LEN_A; i++) exp_a[i] = v.wr_byte[i % 8];
    for (int i = 0; i < LEN_B; i++) exp_b[i] = v.wr_byte[i % 8];
    sel      = v.is_b;
    cur_byte = v.wr_byte;
    wr_data  = v.wr_byte;
    wr_valid = 1'b1;
    rd_ready = (v.stall == 0);
    start    = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    we_cnt = 0; d_err = 0; hs_cnt = 0; net_en_edge = -1;
    rb_q.delete();
    check($sformatf("v%0d_start_busy", idx), m_busy, 1);
    sdone = 1'b0;
    t = 0;
    while (!m_net_en && t < 3000) begin
      if (hs_cnt >= v.nbytes) wr_valid = 1'b0;
      start = (v.start_bit > 0) && !sdone && (we_cnt >= v.start_bit);
      if (start) sdone = 1'b1;
      if (!rd_ready && m_rd_valid) begin
        stall_err = 0;
        repeat (v.stall) begin
          @(negedge clk);
          if (m_wr_ready !== 1'b0 || m_cfg_we !== 1'b0) stall_err++;
        end
        check($sformatf("v%0d_stall_hold", idx), stall_err, 0);
        @(posedge clk); #1;
        rd_ready = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    wr_valid = 1'b0;
    check($sformatf("v%0d_net_en", idx), m_net_en, 1);
    repeat (2) @(posedge clk);
    #1;
    if (v.latency > 0)
      check($sformatf("v%0d_net_en_cycle", idx), net_en_edge - start_edge, v.latency);
    check($sformatf("v%0d_we_cycles", idx), we_cnt, v.nbits);
    check($sformatf("v%0d_cfg_d_pattern_errs", idx), d_err, 0);
    check($sformatf("v%0d_rb_count", idx), rb_q.size(), v.nbytes);
    if (v.check_rb) begin
      for (int j = 0; j < v.nbytes && j < rb_q.size(); j++)
        check($sformatf("v%0d_rb_byte%0d", idx, j), rb_q[j],
              (j == v.nbytes - 1) ? v.rb_last : v.rb_first);
    end
    check($sformatf("v%0d_chain", idx), v.is_b ? (chain_b == exp_b) : (chain_a == exp_a), 1);
    check($sformatf("v%0d_idle_busy", idx), m_busy, 0);
  endtask

  initial begin
    int t;
    int snap;
    vecs[0] = '{is_b:1'b0, wr_byte:8'hA5, rb_first:8'h00, rb_last:8'h00, nbytes:60, nbits:480,
                latency:540, stall:0, start_bit:0, check_rb:1'b1};
    vecs[1] = '{is_b:1'b0, wr_byte:8'h3C, rb_first:8'hA5, rb_last:8'hA5, nbytes:60, nbits:480,
                latency:540, stall:0, start_bit:200, check_rb:1'b1};
    vecs[2] = '{is_b:1'b0, wr_byte:8'h81, rb_first:8'h3C, rb_last:8'h3C, nbytes:60, nbits:480,
                latency:-1, stall:20, start_bit:0, check_rb:1'b1};
    vecs[3] = '{is_b:1'b1, wr_byte:8'hFF, rb_first:8'h5B, rb_last:8'h1A, nbytes:2, nbits:13,
                latency:15, stall:0, start_bit:0, check_rb:1'b1};
    vecs[4] = '{is_b:1'b0, wr_byte:8'h96, rb_first:8'h00, rb_last:8'h00, nbytes:60, nbits:480,
                latency:540, stall:0, start_bit:0, check_rb:1'b0};

    init_chain = 1'b1;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1;
    check("reset_outputs_a", m_outs, 0);
    sel = 1'b1; #1;
    check("reset_outputs_b", m_outs, 0);
    sel = 1'b0;
    init_chain = 1'b0;
    rstb = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_load(vecs[i], i);

    // Abort partway through a load.
    sel = 1'b0; cur_byte = 8'h5A; wr_data = 8'h5A; wr_valid = 1'b1; rd_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; we_cnt = 0; d_err = 0;
    t = 0;
    while (we_cnt < 100 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reached_bit100", (we_cnt >= 100), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wr_valid = 1'b0;
    check("abort_busy", m_busy, 0);
    check("abort_cfg_we", m_cfg_we, 0);
    check("abort_net_en", m_net_en, 0);
    snap = we_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_more_shift", we_cnt, snap);

    // Reset in the middle of shifting.
    cur_byte = 8'hC3; wr_data = 8'hC3; wr_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; we_cnt = 0;
    t = 0;
    while (we_cnt < 50 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("midshift_active", m_cfg_we, 1);
    rstb = 1'b0;
    #1;
    check("midshift_reset_outputs", m_outs, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;

    run_load(vecs[4], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
